m65c02_rmw_seq: RTL
===================

Name: m65c02_rmw_seq

Overview:
- Multi-cycle read-modify-write sequencer for the bit-manipulation instructions TSB, TRB, SMBx and RMBx.
- Fetches the memory operand over a simple request/acknowledge bus, then drives the shared logic unit (op, L and M operands, enable) for exactly one cycle.
- Writes the result back to memory and reports the Z flag update.
- Sits between the core microsequencer (Start/Done) and the logic unit plus the external memory port.

Parameters:
- pTimeout, 15: maximum wait cycles per bus phase before abort; 0 disables the timeout.
- pTW, 4: width of the wait counter; requires pTimeout < 2**pTW.

Ports:
- Clk  input  1  system clock, all state on rising edge.
- Rst_N  input  1  asynchronous active-low reset.
- Start  input  1  one-cycle command strobe; sampled only in IDLE.
- Cmd  input  2  00=TSB, 01=TRB, 10=SMBx, 11=RMBx; latched on Start.
- BitSel  input  3  bit index for SMBx/RMBx; latched on Start.
- A  input  8  accumulator; latched on Start.
- Busy  output  1  high in every state except IDLE.
- MemReq  output  1  bus request, registered.
- MemWr  output  1  1=write, 0=read; valid while MemReq.
- MemAck  input  1  bus acknowledge, completes the current phase.
- DI  input  8  read data, valid with MemAck in RD.
- DO  output  8  write data, registered.
- LU_En  output  1  logic-unit enable.
- LU_Op  output  2  logic-unit op: 00 = ~L&M, 10 = L|M.
- LU_L  output  8  logic-unit L operand.
- LU_M  output  8  logic-unit M operand.
- LU_Out  input  8  logic-unit result, low 8 bits.
- LU_Z  input  1  logic-unit ~|(L&M).
- Done  output  1  one-cycle completion pulse.
- Err  output  1  valid with Done; 1 = bus timeout.
- Z_Wr  output  1  one-cycle strobe with Done: load Z flag.
- Z_Out  output  1  new Z value, valid with Z_Wr.

Behaviour:
- Reset: every output 0, state IDLE, all internal registers cleared.
  - Reset asserted mid-operation forces IDLE immediately; MemReq drops asynchronously.
  - A pending write is never completed after reset.
- States and transitions: IDLE, RD, MOD, WR, DONE.
  - IDLE: on Start, latch Cmd, BitSel and A, clear the wait counter, go to RD.
  - RD: MemReq=1, MemWr=0. On MemAck, latch DI into Mreg and go to MOD. MemAck in the same cycle as entry to RD counts.
  - MOD: LU_En=1 for exactly one cycle. LU_M=Mreg.
    - TSB: LU_L=A, LU_Op=10.
    - TRB: LU_L=A, LU_Op=00.
    - SMBx: LU_L=1<<BitSel, LU_Op=10.
    - RMBx: LU_L=1<<BitSel, LU_Op=00.
    - Capture LU_Out into Wreg and LU_Z into Zreg. Go to WR.
  - WR: MemReq=1, MemWr=1, DO=Wreg. On MemAck go to DONE.
  - DONE: Done=1, Err=0. For Cmd 00/01 only: Z_Wr=1, Z_Out=Zreg. Return to IDLE.
- Z semantics: Z is computed from the original memory value, Z = ~|(A & Mold). It is never computed from the written value.
- Outside MOD, LU_En=0 and LU_Op/LU_L/LU_M=0. The LU then outputs 0, keeping the shared datapath quiet.
- Zero-wait latency, by cycle after the Start edge:
  - RD: cycle 1.
  - MOD: cycle 2.
  - WR: cycle 3.
  - Done: cycle 4.
  - Total 4 cycles to Done; each wait cycle adds 1.
- Timeout, when pTimeout > 0:
  - The wait counter increments each RD/WR cycle without MemAck and resets on phase change.
  - When the counter equals pTimeout with no MemAck, drop MemReq and go to DONE with Err=1, Z_Wr=0.
  - A timeout in RD skips MOD and WR; no write occurs.
  - MemAck arriving in the same cycle as the timeout wins (normal completion).
- Start while Busy is ignored. It is not queued and does not alter latched operands.
- MemAck while MemReq=0 is ignored.
- Start in the same cycle as Done (DONE state) is ignored; the next Start is accepted in IDLE only.
- DO holds Wreg through WR and is zeroed in IDLE.

Decomposition:
- Shared package (m65c02_pkg) holds:
  - Cmd encodings: CMD_TSB, CMD_TRB, CMD_SMB, CMD_RMB.
  - LU op constants: LU_TRB=00, LU_AND=01, LU_ORA=10, LU_EOR=11.
  - State encoding constants.
- One natural sub-module: m65c02_bus_wdog, the wait counter plus timeout compare (Clr, Cnt_En, Expired). It is reusable by other multi-cycle sequencers.
- Bit-mask decode stays inline.

Test Plan:
- TSB, A=0x0F, DI=0x30, zero-wait: expect the following, with the LU model in loop.
  - Read at cycle 1.
  - LU_Op=10, LU_L=0x0F, LU_M=0x30 at cycle 2.
  - Write DO=0x3F at cycle 3.
  - Done, Z_Wr=1, Z_Out=1 at cycle 4.
- TRB, A=0x30, DI=0x3C, 2 wait cycles on each phase -> DO=0x0C, Z_Out=0, Done at cycle 8.
- SMB5, DI=0x00 -> DO=0x20, Z_Wr=0. Then RMB0, DI=0xFF -> DO=0xFE, Z_Wr=0.
- Start pulsed during RD with different Cmd/A -> ignored; the original operation completes with the original result.
- pTimeout=3, MemAck withheld in RD -> MemReq drops, no MemWr ever seen, Done=1, Err=1, Z_Wr=0. Then MemAck coincident with the timeout cycle -> normal completion.
- Rst_N low during WR with MemReq=1 -> MemReq/MemWr/Busy go to 0 without a clock edge. After release, IDLE; a new TSB completes normally.

Source files
------------

// File: rtl/m65c02_pkg.sv
// Shared encodings for the 65C02 bit-manipulation read-modify-write path.
// Command codes, logic-unit op codes and sequencer state encoding.
package m65c02_pkg;

    typedef enum logic [1:0] {
        CMD_TSB = 2'b00,
        CMD_TRB = 2'b01,
        CMD_SMB = 2'b10,
        CMD_RMB = 2'b11
    } cmd_e;

    localparam logic [1:0] LU_TRB = 2'b00;
    localparam logic [1:0] LU_AND = 2'b01;
    localparam logic [1:0] LU_ORA = 2'b10;
    localparam logic [1:0] LU_EOR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_MOD  = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/m65c02_rmw_seq_if.sv
// Command, memory-bus and logic-unit signals of the RMW sequencer.
// master = sequencer side, slave = core / memory / logic-unit side.
interface m65c02_rmw_seq_if;

    logic       start;
    logic [1:0] cmd;
    logic [2:0] bit_sel;
    logic [7:0] a;
    logic       busy;
    logic       done;
    logic       err;
    logic       z_wr;
    logic       z_out;

    logic       mem_req;
    logic       mem_wr;
    logic       mem_ack;
    logic [7:0] mem_di;
    logic [7:0] mem_do;

    logic       lu_en;
    logic [1:0] lu_op;
    logic [7:0] lu_l;
    logic [7:0] lu_m;
    logic [7:0] lu_out;
    logic       lu_z;

    modport master (
        input  start, cmd, bit_sel, a, mem_ack, mem_di, lu_out, lu_z,
        output busy, done, err, z_wr, z_out, mem_req, mem_wr, mem_do,
               lu_en, lu_op, lu_l, lu_m
    );

    modport slave (
        output start, cmd, bit_sel, a, mem_ack, mem_di, lu_out, lu_z,
        input  busy, done, err, z_wr, z_out, mem_req, mem_wr, mem_do,
               lu_en, lu_op, lu_l, lu_m
    );

endinterface

// File: rtl/m65c02_bus_wdog.sv
// Bus-phase wait counter; expired flags pTimeout waits (0 disables), zero latency.
// No backpressure: clr has priority over cnt_en.
module m65c02_bus_wdog #(
    parameter int pTimeout = 15,
    parameter int pTW      = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic cnt_en,
    output logic expired
);

    logic [pTW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (cnt_en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (pTimeout != 0) && (cnt == pTW'(pTimeout));

endmodule

// File: rtl/m65c02_rmw_seq.sv
// TSB/TRB/SMBx/RMBx read-modify-write sequencer: read, one LU cycle, write, done.
// Latency 4 cycles Start-to-Done plus bus waits; each phase waits on mem_ack or aborts on timeout.
module m65c02_rmw_seq
    import m65c02_pkg::*;
#(
    parameter int pTimeout = 15,
    parameter int pTW      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    m65c02_rmw_seq_if.master bus
);

    state_e     state, state_nxt;
    logic [1:0] cmd_q;
    logic [2:0] bit_q;
    logic [7:0] a_q, mreg, wreg;
    logic       zreg, err_q, mem_req_q, mem_wr_q;
    logic       wd_clr, wd_en, wd_expired, abort;
    logic       lu_en;
    logic [1:0] lu_op;
    logic [7:0] lu_l, lu_m;

    m65c02_bus_wdog #(.pTimeout(pTimeout), .pTW(pTW)) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wd_clr),
        .cnt_en  (wd_en),
        .expired (wd_expired)
    );

    always_comb begin
        state_nxt = state;
        wd_en     = 1'b0;
        abort     = 1'b0;
        lu_en     = 1'b0;
        lu_op     = 2'b00;
        lu_l      = '0;
        lu_m      = '0;
        case (state)
            ST_IDLE: if (bus.start) state_nxt = ST_RD;
            ST_RD, ST_WR: begin
                // An ack in the timeout cycle still completes the phase normally.
                if (bus.mem_ack) begin
                    state_nxt = (state == ST_RD) ? ST_MOD : ST_DONE;
                end else if (wd_expired) begin
                    state_nxt = ST_DONE;
                    abort     = 1'b1;
                end else begin
                    wd_en = 1'b1;
                end
            end
            ST_MOD: begin
                lu_en     = 1'b1;
                lu_m      = mreg;
                lu_l      = cmd_q[1] ? (8'b1 << bit_q) : a_q;
                lu_op     = (cmd_q == CMD_TSB || cmd_q == CMD_SMB) ? LU_ORA : LU_TRB;
                state_nxt = ST_WR;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        wd_clr = (state == ST_IDLE) || (state_nxt != state);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cmd_q     <= '0;
            bit_q     <= '0;
            a_q       <= '0;
            mreg      <= '0;
            wreg      <= '0;
            zreg      <= 1'b0;
            err_q     <= 1'b0;
            mem_req_q <= 1'b0;
            mem_wr_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            mem_req_q <= (state_nxt == ST_RD) || (state_nxt == ST_WR);
            mem_wr_q  <= (state_nxt == ST_WR);
            if (state == ST_IDLE && bus.start) begin
                cmd_q <= bus.cmd;
                bit_q <= bus.bit_sel;
                a_q   <= bus.a;
                err_q <= 1'b0;
            end
            if (state == ST_RD && bus.mem_ack) mreg <= bus.mem_di;
            if (abort) err_q <= 1'b1;
            // Z comes from the original operand (LU_Z = ~|(L&M)), never from the written value.
            if (state == ST_MOD) begin
                wreg <= bus.lu_out;
                zreg <= bus.lu_z;
            end else if (state_nxt != ST_WR) begin
                wreg <= '0;
            end
        end
    end

    assign bus.busy    = (state != ST_IDLE);
    assign bus.done    = (state == ST_DONE);
    assign bus.err     = (state == ST_DONE) && err_q;
    assign bus.z_wr    = (state == ST_DONE) && !err_q &&
                         (cmd_q == CMD_TSB || cmd_q == CMD_TRB);
    assign bus.z_out   = bus.z_wr && zreg;
    assign bus.mem_req = mem_req_q;
    assign bus.mem_wr  = mem_wr_q;
    assign bus.mem_do  = wreg;
    assign bus.lu_en   = lu_en;
    assign bus.lu_op   = lu_op;
    assign bus.lu_l    = lu_l;
    assign bus.lu_m    = lu_m;

endmodule
